// File: rtl/line_buffer_nk.sv
// Vertical line buffer: keeps the last KERNEL_SIZE complete lines (plus the line being written)
// and emits a KERNEL_SIZE-pixel column per input pixel with optional top/bottom border handling.
module line_buffer_nk #(
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int HRES        = 1280,
  parameter int VRES        = 720
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic [10:0]                            hcount_in,
  input  logic [9:0]                             vcount_in,
  input  logic [DATA_WIDTH-1:0]                  pixel_data_in,
  input  logic                                   data_valid_in,
  input  logic [1:0]                             border_mode_in,
  output logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] line_buffer_out,
  output logic [10:0]                            hcount_out,
  output logic [9:0]                             vcount_out,
  output logic                                   data_valid_out
);

  localparam int NB   = KERNEL_SIZE + 1;
  localparam int HALF = KERNEL_SIZE / 2;
  localparam int AW   = $clog2(HRES);
  localparam int SW   = $clog2(NB);

  localparam logic [10:0]        H_LAST  = 11'(HRES - 1);
  localparam logic signed [11:0] S_HALF  = 12'(HALF);
  localparam logic signed [11:0] S_OFF   = 12'(HALF + 1);
  localparam logic signed [11:0] S_VRES  = 12'(VRES);
  localparam logic signed [11:0] S_VLAST = 12'(VRES - 1);

  logic [NB-1:0]                  r_wp;
  logic [SW-1:0]                  w_wr_idx;
  logic signed [11:0]             w_vc_raw;
  logic signed [11:0]             w_vc;
  logic [KERNEL_SIZE-1:0][SW-1:0] w_sel;
  logic [KERNEL_SIZE-1:0]         w_zero;

  logic [KERNEL_SIZE-1:0][SW-1:0] r_sel1, r_sel2;
  logic [KERNEL_SIZE-1:0]         r_zero1, r_zero2;
  logic [10:0]                    r_hc1, r_hc2;
  logic [9:0]                     r_vc1, r_vc2;
  logic                           r_dv1, r_dv2;

  logic [AW-1:0]                  r_rd_addr;
  logic [DATA_WIDTH-1:0]          w_dout [NB];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_wp <= NB'(1);
    end else if (data_valid_in && hcount_in == H_LAST) begin
      r_wp <= {r_wp[NB-2:0], r_wp[NB-1]};
    end
  end

  always_comb begin
    w_wr_idx = '0;
    for (int i = 0; i < NB; i++) begin
      if (r_wp[i]) w_wr_idx = SW'(i);
    end
  end

  // Centre line lags the input by HALF+1 because the current line is still being written.
  assign w_vc_raw = $signed({2'b00, vcount_in}) - S_OFF;
  assign w_vc     = w_vc_raw[11] ? w_vc_raw + S_VRES : w_vc_raw;

  always_comb begin
    logic signed [11:0] v_line;
    logic signed [11:0] v_src;
    int                 v_buf;
    w_sel  = '0;
    w_zero = '0;
    v_line = '0;
    v_src  = '0;
    v_buf  = 0;
    for (int j = 0; j < KERNEL_SIZE; j++) begin
      v_line = w_vc - S_HALF + 12'(j);
      v_src  = 12'(j);
      case (border_mode_in)
        2'd1: w_zero[j] = v_line[11] || (v_line > S_VLAST);
        2'd2: begin
          if (v_line[11])             v_src = S_HALF - w_vc;
          else if (v_line > S_VLAST)  v_src = S_VLAST - w_vc + S_HALF;
        end
        default: ;
      endcase
      // Row s lives in the buffer s+1 places after the write pointer.
      v_buf = int'(w_wr_idx) + 1 + int'(v_src);
      if (v_buf >= NB) v_buf = v_buf - NB;
      w_sel[j] = SW'(v_buf);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_sel1  <= '0;
      r_sel2  <= '0;
      r_zero1 <= '1;
      r_zero2 <= '1;
      r_hc1   <= '0;
      r_hc2   <= '0;
      r_vc1   <= '0;
      r_vc2   <= '0;
      r_dv1   <= 1'b0;
      r_dv2   <= 1'b0;
    end else begin
      r_sel1  <= w_sel;
      r_sel2  <= r_sel1;
      r_zero1 <= w_zero;
      r_zero2 <= r_zero1;
      r_hc1   <= hcount_in;
      r_hc2   <= r_hc1;
      r_vc1   <= w_vc[9:0];
      r_vc2   <= r_vc1;
      r_dv1   <= data_valid_in;
      r_dv2   <= r_dv1;
    end
  end

  // NOTE: BRAM storage and its read registers have no reset; zeroed output after reset comes from r_zero2.
  always_ff @(posedge clk_in) begin
    r_rd_addr <= hcount_in[AW-1:0];
  end

  for (genvar i = 0; i < NB; i++) begin : g_bram
    logic [DATA_WIDTH-1:0] r_mem [HRES];
    logic [DATA_WIDTH-1:0] r_dout;

    always_ff @(posedge clk_in) begin
      if (data_valid_in && r_wp[i]) r_mem[hcount_in[AW-1:0]] <= pixel_data_in;
      r_dout <= r_mem[r_rd_addr];
    end

    assign w_dout[i] = r_dout;
  end

  always_comb begin
    line_buffer_out = '0;
    for (int j = 0; j < KERNEL_SIZE; j++) begin
      if (!r_zero2[j]) line_buffer_out[j] = w_dout[r_sel2[j]];
    end
  end

  assign hcount_out     = r_hc2;
  assign vcount_out     = r_vc2;
  assign data_valid_out = r_dv2;

endmodule

// File: tb/tb_line_buffer_nk.sv
// Bench for line_buffer_nk: a K=3/8-bit and a K=5/10-bit instance share one stimulus stream and
// are compared each cycle against a slot-level reference model plus directed column checks.
module tb_line_buffer_nk;

  localparam int HRES = 8;
  localparam int VRES = 6;
  localparam int KA   = 3;
  localparam int KB   = 5;

  typedef struct packed {
    logic            valid;
    logic [10:0]     h;
    logic [9:0]      vc;
    logic [6:0][9:0] val;
    logic [6:0]      known;
  } exp_t;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic             rst_in;
  logic [10:0]      hcount_in;
  logic [9:0]       vcount_in;
  logic [7:0]       pix_a;
  logic [9:0]       pix_b;
  logic             data_valid_in;
  logic [1:0]       border_mode_in;

  logic [KA-1:0][7:0] lb_a;
  logic [10:0]        hc_a;
  logic [9:0]         vc_a;
  logic               dv_a;
  logic [KB-1:0][9:0] lb_b;
  logic [10:0]        hc_b;
  logic [9:0]         vc_b;
  logic               dv_b;

  line_buffer_nk #(.KERNEL_SIZE(KA), .DATA_WIDTH(8), .HRES(HRES), .VRES(VRES)) dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .pixel_data_in(pix_a), .data_valid_in(data_valid_in), .border_mode_in(border_mode_in),
    .line_buffer_out(lb_a), .hcount_out(hc_a), .vcount_out(vc_a), .data_valid_out(dv_a)
  );

  line_buffer_nk #(.KERNEL_SIZE(KB), .DATA_WIDTH(10), .HRES(HRES), .VRES(VRES)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .pixel_data_in(pix_b), .data_valid_in(data_valid_in), .border_mode_in(border_mode_in),
    .line_buffer_out(lb_b), .hcount_out(hc_b), .vcount_out(vc_b), .data_valid_out(dv_b)
  );

  // Reference state: per instance, K+1 line slots, which slot is being filled, and whether a cell was ever written.
  int   mem   [2][8][8];
  bit   kn    [2][8][8];
  int   wslot [2];
  exp_t pipe  [2][2];

  int n_vec = 0;
  int n_err = 0;
  int cur_f = -1;
  int in_f1 = -1, in_h1 = 0, in_v1 = 0;
  int in_f2 = -1, in_h2 = 0, in_v2 = 0;

  logic [91:0] act_a, exp_a, act_b, exp_b;

  function automatic int ks(input int d);
    return (d == 0) ? KA : KB;
  endfunction

  function automatic exp_t zero_e();
    exp_t e;
    e = '0;
    e.known = '1;
    return e;
  endfunction

  // Column for one input: stored lines oldest-first, row j shows line vc-half+j, clamped or zeroed at the frame edges.
  function automatic exp_t model(input int d, input int h, input int v, input bit dv, input int mode);
    exp_t e;
    int k, half, vc, line, cl, src, slot;
    bit oor;
    k = ks(d);
    half = k / 2;
    e = '0;
    e.valid = dv;
    e.h = 11'(h);
    vc = v - (half + 1);
    if (vc < 0) vc += VRES;
    e.vc = 10'(vc);
    for (int j = 0; j < k; j++) begin
      line = vc - half + j;
      oor  = (line < 0) || (line > VRES - 1);
      cl   = (line < 0) ? 0 : ((line > VRES - 1) ? VRES - 1 : line);
      src  = (mode == 2) ? cl - (vc - half) : j;
      slot = (wslot[d] + 1 + src) % (k + 1);
      if (mode == 1 && oor) begin
        e.known[j] = 1'b1;
        e.val[j]   = '0;
      end else begin
        e.known[j] = kn[d][slot][h];
        e.val[j]   = 10'(mem[d][slot][h]);
      end
    end
    return e;
  endfunction

  task automatic tick(input int h, input int v, input int pix, input bit dv, input int mode, input bit rst);
    exp_t e [2];
    exp_t p;
    rst_in         = !rst;
    hcount_in      = 11'(h);
    vcount_in      = 10'(v);
    pix_a          = 8'(pix);
    pix_b          = 10'(pix);
    data_valid_in  = dv;
    border_mode_in = 2'(mode);
    for (int d = 0; d < 2; d++) e[d] = model(d, h, v, dv, mode);
    @(posedge clk_in);
    for (int d = 0; d < 2; d++) begin
      if (dv) begin
        mem[d][wslot[d]][h] = pix;
        kn[d][wslot[d]][h]  = 1'b1;
      end
      if (rst) begin
        wslot[d]   = 0;
        pipe[d][0] = zero_e();
        pipe[d][1] = zero_e();
      end else begin
        if (dv && h == HRES - 1) wslot[d] = (wslot[d] + 1) % (ks(d) + 1);
        pipe[d][1] = pipe[d][0];
        pipe[d][0] = e[d];
      end
    end
    in_f2 = rst ? -1 : in_f1;
    in_h2 = in_h1;
    in_v2 = in_v1;
    in_f1 = rst ? -1 : cur_f;
    in_h1 = h;
    in_v1 = v;
    #1;
    p = pipe[0][1];
    exp_a = '0;
    act_a = '0;
    exp_a[91:70] = {p.valid, p.h, p.vc};
    act_a[91:70] = {dv_a, hc_a, vc_a};
    for (int j = 0; j < KA; j++) begin
      if (p.known[j]) begin
        exp_a[j*10 +: 10] = {2'b00, p.val[j][7:0]};
        act_a[j*10 +: 10] = {2'b00, lb_a[j]};
      end
    end
    p = pipe[1][1];
    exp_b = '0;
    act_b = '0;
    exp_b[91:70] = {p.valid, p.h, p.vc};
    act_b[91:70] = {dv_b, hc_b, vc_b};
    for (int j = 0; j < KB; j++) begin
      if (p.known[j]) begin
        exp_b[j*10 +: 10] = p.val[j];
        act_b[j*10 +: 10] = lb_b[j];
      end
    end
  endtask

  task automatic test_reset();
    cur_f = -1;
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    n_vec++;
    if ({dv_a, hc_a, vc_a, lb_a} !== '0) begin
      n_err++;
      $display("FAIL reset_a got=%h want=0", {dv_a, hc_a, vc_a, lb_a});
    end
    n_vec++;
    if ({dv_b, hc_b, vc_b, lb_b} !== '0) begin
      n_err++;
      $display("FAIL reset_b got=%h want=0", {dv_b, hc_b, vc_b, lb_b});
    end
  endtask

  task automatic test_fill();
    cur_f = 0;
    for (int v = 0; v < VRES; v++) begin
      for (int h = 0; h < HRES; h++) begin
        tick(h, v, 16 * v + h, 1'b1, 0, 1'b0);
        n_vec += 2;
        if (act_a !== exp_a) begin n_err++; $display("FAIL fill_a got=%h want=%h", act_a, exp_a); end
        if (act_b !== exp_b) begin n_err++; $display("FAIL fill_b got=%h want=%h", act_b, exp_b); end
        if (in_f2 == 0 && in_v2 == 3) begin
          n_vec++;
          if (hc_a !== 11'(in_h2) || vc_a !== 10'd1 || dv_a !== 1'b1) begin
            n_err++;
            $display("FAIL fill_timing got=h%0d v%0d dv%0b want=h%0d v1 dv1", hc_a, vc_a, dv_a, in_h2);
          end
        end
        if (in_f2 == 0 && in_v2 == 3 && in_h2 == 4) begin
          n_vec++;
          if (lb_a !== {8'h24, 8'h14, 8'h04}) begin n_err++; $display("FAIL fill_col4 got=%h want=241404", lb_a); end
        end
        if (in_f2 == 0 && in_v2 == 3 && in_h2 == 7) begin
          n_vec++;
          if (lb_a !== {8'h27, 8'h17, 8'h07}) begin n_err++; $display("FAIL rot_last got=%h want=271707", lb_a); end
        end
        if (in_f2 == 0 && in_v2 == 4 && in_h2 == 0) begin
          n_vec++;
          if (lb_a !== {8'h30, 8'h20, 8'h10}) begin n_err++; $display("FAIL rot_first got=%h want=302010", lb_a); end
        end
      end
    end
  endtask

  task automatic test_zero_fill();
    cur_f = 1;
    for (int v = 0; v < VRES; v++) begin
      for (int h = 0; h < HRES; h++) begin
        tick(h, v, 16 * v + h, 1'b1, 1, 1'b0);
        n_vec += 2;
        if (act_a !== exp_a) begin n_err++; $display("FAIL zero_a got=%h want=%h", act_a, exp_a); end
        if (act_b !== exp_b) begin n_err++; $display("FAIL zero_b got=%h want=%h", act_b, exp_b); end
        if (in_f2 == 1 && in_h2 == 3 && in_v2 == 1) begin
          n_vec++;
          if (vc_a !== 10'd5 || lb_a[2] !== 8'h00) begin
            n_err++;
            $display("FAIL zero_bottom got=v%0d row2=%h want=v5 row2=00", vc_a, lb_a[2]);
          end
        end
        if (in_f2 == 1 && in_h2 == 3 && in_v2 == 2) begin
          n_vec++;
          if (vc_a !== 10'd0 || lb_a[0] !== 8'h00) begin
            n_err++;
            $display("FAIL zero_top got=v%0d row0=%h want=v0 row0=00", vc_a, lb_a[0]);
          end
        end
        if (in_f2 == 1 && in_h2 == 3 && in_v2 == 4) begin
          n_vec++;
          if (vc_b !== 10'd1 || lb_b !== {10'h033, 10'h023, 10'h013, 10'h003, 10'h000}) begin
            n_err++;
            $display("FAIL zero_k5 got=v%0d col=%h want=v1 col=033023013003000", vc_b, lb_b);
          end
        end
      end
    end
  endtask

  task automatic test_replicate();
    for (int f = 2; f < 4; f++) begin
      cur_f = f;
      for (int v = 0; v < ((f == 2) ? VRES : 2); v++) begin
        for (int h = 0; h < HRES; h++) begin
          tick(h, v, 16 * v + h, 1'b1, 2, 1'b0);
          n_vec += 2;
          if (act_a !== exp_a) begin n_err++; $display("FAIL repl_a got=%h want=%h", act_a, exp_a); end
          if (act_b !== exp_b) begin n_err++; $display("FAIL repl_b got=%h want=%h", act_b, exp_b); end
          if (in_f2 == 2 && in_v2 == 2 && in_h2 == 3) begin
            n_vec++;
            if (vc_a !== 10'd0 || lb_a !== {8'h13, 8'h03, 8'h03}) begin
              n_err++;
              $display("FAIL repl_top got=v%0d col=%h want=v0 col=130303", vc_a, lb_a);
            end
          end
          if (in_f2 == 3 && in_v2 == 1 && in_h2 == 3) begin
            n_vec++;
            if (vc_a !== 10'd5 || lb_a !== {8'h53, 8'h53, 8'h43}) begin
              n_err++;
              $display("FAIL repl_bottom got=v%0d col=%h want=v5 col=535343", vc_a, lb_a);
            end
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int col, line;
    bit dv;
    cur_f = 4;
    col  = 0;
    line = 2;
    for (int c = 0; c < 400; c++) begin
      dv = ($urandom_range(0, 3) != 0);
      if (dv) begin
        tick(col, line, $urandom_range(0, 1023), 1'b1, $urandom_range(0, 3), 1'b0);
        col++;
        if (col == HRES) begin
          col  = 0;
          line = (line + 1) % VRES;
        end
      end else begin
        tick($urandom_range(0, HRES - 1), $urandom_range(0, VRES - 1), $urandom_range(0, 1023),
             1'b0, $urandom_range(0, 3), 1'b0);
      end
      n_vec += 2;
      if (act_a !== exp_a) begin n_err++; $display("FAIL rand_a got=%h want=%h", act_a, exp_a); end
      if (act_b !== exp_b) begin n_err++; $display("FAIL rand_b got=%h want=%h", act_b, exp_b); end
    end
  endtask

  task automatic test_reset_midline();
    int col, line;
    cur_f = 5;
    for (int h = 0; h < 4; h++) begin
      tick(h, 3, $urandom_range(0, 1023), 1'b1, 0, 1'b0);
      n_vec += 2;
      if (act_a !== exp_a) begin n_err++; $display("FAIL pre_rst_a got=%h want=%h", act_a, exp_a); end
      if (act_b !== exp_b) begin n_err++; $display("FAIL pre_rst_b got=%h want=%h", act_b, exp_b); end
    end
    tick(4, 3, 0, 1'b0, 0, 1'b1);
    n_vec++;
    if ({dv_a, hc_a, vc_a, lb_a, dv_b, hc_b, vc_b, lb_b} !== '0) begin
      n_err++;
      $display("FAIL midline_rst got=%h want=0", {dv_a, hc_a, vc_a, lb_a, dv_b, hc_b, vc_b, lb_b});
    end
    col  = 0;
    line = 0;
    for (int c = 0; c < 100; c++) begin
      if (c % 2 == 0) begin
        tick(col, line, $urandom_range(0, 1023), 1'b1, $urandom_range(0, 3), 1'b0);
        col++;
        if (col == HRES) begin
          col  = 0;
          line = (line + 1) % VRES;
        end
      end else begin
        tick(HRES - 1, line, $urandom_range(0, 1023), 1'b0, $urandom_range(0, 3), 1'b0);
      end
      if (c == 0) begin
        n_vec++;
        if ({dv_a, lb_a, dv_b, lb_b} !== '0) begin
          n_err++;
          $display("FAIL post_rst_flush got=%h want=0", {dv_a, lb_a, dv_b, lb_b});
        end
      end
      n_vec += 2;
      if (act_a !== exp_a) begin n_err++; $display("FAIL gap_a got=%h want=%h", act_a, exp_a); end
      if (act_b !== exp_b) begin n_err++; $display("FAIL gap_b got=%h want=%h", act_b, exp_b); end
    end
  endtask

  initial begin
    wslot[0] = 0;
    wslot[1] = 0;
    for (int d = 0; d < 2; d++) begin
      pipe[d][0] = zero_e();
      pipe[d][1] = zero_e();
    end
    test_reset();
    test_fill();
    test_zero_fill();
    test_replicate();
    test_random();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
